// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: boot flush, taken-branch redirect, multi-cycle data-memory
// stalls with timeout abort, load-use interlock and a saturating stall counter.
module pipeline_hazard_ctrl #(
  parameter int BOOT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_load,
  input  logic             ex_reg_write,
  input  logic             ex_mem_en,
  input  logic             ex_br_taken,
  input  logic             ex_jump,
  input  logic             dmem_ready,
  input  logic             perf_clr,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             pc_redirect,
  output logic             dmem_req,
  output logic             mem_abort,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_MEM_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    boot_cnt_q, boot_cnt_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic redirect;

  // x0 is hard-wired zero, so a load targeting it can never create a hazard.
  assign load_use = ex_load & ex_reg_write & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign redirect = ex_br_taken | ex_jump;

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    bubble_ex   = 1'b0;
    flush_id    = 1'b0;
    pc_redirect = 1'b0;
    dmem_req    = 1'b0;
    mem_abort   = 1'b0;

    case (state_q)
      ST_BOOT: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
        if (boot_cnt_q == BW'(BOOT_CYCLES - 1)) begin
          boot_cnt_d = '0;
          state_d    = ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (redirect) begin
          pc_redirect = 1'b1;
          flush_id    = 1'b1;
          bubble_ex   = 1'b1;
        end else if (ex_mem_en) begin
          dmem_req = 1'b1;
          if (dmem_ready) begin
            if (load_use) begin
              stall_if  = 1'b1;
              stall_id  = 1'b1;
              bubble_ex = 1'b1;
            end
          end else begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            stall_ex   = 1'b1;
            wait_cnt_d = WW'(1);
            state_d    = ST_MEM_WAIT;
          end
        end else if (load_use) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          // The completing load may still feed the ID instruction.
          wait_cnt_d = '0;
          state_d    = ST_RUN;
          if (load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
          end
        end else if (wait_cnt_q == WW'(MEM_TIMEOUT - 1)) begin
          mem_abort  = 1'b1;
          mem_err_d  = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_RUN;
        end else begin
          stall_if   = 1'b1;
          stall_id   = 1'b1;
          stall_ex   = 1'b1;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = '0;
    end else if (stall_if && (state_q != ST_BOOT) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: each step pushes its expected control vector and
// stall count into a scoreboard queue, then pops and compares against the DUT mid-cycle.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2;
  logic        ex_load, ex_reg_write, ex_mem_en, ex_br_taken, ex_jump;
  logic        dmem_ready, perf_clr;
  logic        stall_if, stall_id, stall_ex, bubble_ex, flush_id;
  logic        pc_redirect, dmem_req, mem_abort, mem_err;
  logic [15:0] stall_cnt;

  pipeline_hazard_ctrl #(.BOOT_CYCLES(4), .MEM_TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_load(ex_load), .ex_reg_write(ex_reg_write), .ex_mem_en(ex_mem_en),
    .ex_br_taken(ex_br_taken), .ex_jump(ex_jump), .dmem_ready(dmem_ready), .perf_clr(perf_clr),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .bubble_ex(bubble_ex),
    .flush_id(flush_id), .pc_redirect(pc_redirect), .dmem_req(dmem_req),
    .mem_abort(mem_abort), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // {stall_if, stall_id, stall_ex, bubble_ex, flush_id, pc_redirect, dmem_req, mem_abort}
  localparam logic [7:0] BOOTV  = 8'b1101_1000;
  localparam logic [7:0] IDLE   = 8'b0000_0000;
  localparam logic [7:0] LU     = 8'b1101_0000;
  localparam logic [7:0] LU_MEM = 8'b1101_0010;
  localparam logic [7:0] MEMV   = 8'b0000_0010;
  localparam logic [7:0] WAITV  = 8'b1110_0010;
  localparam logic [7:0] ABORTV = 8'b0000_0011;
  localparam logic [7:0] REDIR  = 8'b0001_1100;

  typedef struct {
    string       tag;
    logic [8:0]  ctl;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic        exp_err;
  logic        in_boot;
  logic [15:0] cnt_model;

  task automatic clr_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_load = 1'b0; ex_reg_write = 1'b0; ex_mem_en = 1'b0;
    ex_br_taken = 1'b0; ex_jump = 1'b0; dmem_ready = 1'b0; perf_clr = 1'b0;
  endtask

  // Called right after a falling edge with inputs already driven; returns at the next one.
  task automatic step(input string tag, input logic [7:0] ctl);
    exp_t e;
    logic [8:0] obs;
    e.tag = tag;
    e.ctl = {ctl, exp_err};
    e.cnt = cnt_model;
    sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    obs = {stall_if, stall_id, stall_ex, bubble_ex, flush_id, pc_redirect, dmem_req,
           mem_abort, mem_err};
    checks++;
    assert (obs === e.ctl) else begin
      errors++;
      $error("FAIL %s ctl: observed=%b expected=%b", e.tag, obs, e.ctl);
    end
    checks++;
    assert (stall_cnt === e.cnt) else begin
      errors++;
      $error("FAIL %s stall_cnt: observed=%0d expected=%0d", e.tag, stall_cnt, e.cnt);
    end
    $display("step %-12s ctl=%b cnt=%0d", e.tag, obs, stall_cnt);
    if (perf_clr) cnt_model = '0;
    else if (ctl[7] && !in_boot) cnt_model = cnt_model + 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_boot = 1'b1;
    exp_err = 1'b0;
    cnt_model = '0;
    step("rst", BOOTV);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step($sformatf("boot%0d", i), BOOTV);
    in_boot = 1'b0;
  endtask

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_inputs();
    @(negedge clk);
    do_reset();
    step("t1_run", IDLE);

    // load-use via rs2 while the load completes in one cycle
    ex_load = 1; ex_reg_write = 1; ex_mem_en = 1; ex_rd = 5'd5;
    id_rs2 = 5'd5; id_use_rs2 = 1; dmem_ready = 1;
    step("t2_lu_mem", LU_MEM);
    clr_inputs();
    step("t2_after", IDLE);

    ex_load = 1; ex_reg_write = 1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1;
    step("lu_rs1", LU);
    clr_inputs();
    step("lu_after", IDLE);

    ex_load = 1; ex_reg_write = 1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 0;
    step("lu_nouse", IDLE);

    clr_inputs();
    ex_load = 1; ex_reg_write = 1; ex_mem_en = 1; ex_rd = 5'd0;
    id_rs1 = 5'd0; id_use_rs1 = 1; dmem_ready = 1;
    step("t3_x0", MEMV);

    // store with a slow memory; a taken branch during the wait is ignored
    clr_inputs();
    ex_mem_en = 1;
    step("t4_issue", WAITV);
    step("t4_wait1", WAITV);
    ex_br_taken = 1;
    step("t4_wait_br", WAITV);
    ex_br_taken = 0; dmem_ready = 1;
    step("t4_ready", MEMV);
    clr_inputs();
    step("t4_after", IDLE);

    // slow load whose completion cycle also interlocks the dependent ID instruction
    ex_load = 1; ex_reg_write = 1; ex_mem_en = 1; ex_rd = 5'd3;
    id_rs1 = 5'd3; id_use_rs1 = 1;
    step("ld_issue", WAITV);
    dmem_ready = 1;
    step("ld_ready_lu", LU_MEM);
    clr_inputs();
    step("ld_after", IDLE);

    ex_br_taken = 1; ex_load = 1; ex_reg_write = 1; ex_rd = 5'd4;
    id_rs1 = 5'd4; id_use_rs1 = 1;
    step("t6_br_lu", REDIR);
    clr_inputs();
    ex_jump = 1; ex_mem_en = 1;
    step("t6_jump_mem", REDIR);
    clr_inputs();
    step("t6_after", IDLE);

    ex_load = 1; ex_reg_write = 1; ex_rd = 5'd8; id_rs2 = 5'd8; id_use_rs2 = 1; perf_clr = 1;
    step("clr_stall", LU);
    clr_inputs();
    step("clr_after", IDLE);

    // memory never answers: 15 stalled request cycles, then the abort cycle
    ex_mem_en = 1;
    for (int i = 0; i < 15; i++) step($sformatf("t5_wait%0d", i), WAITV);
    step("t5_abort", ABORTV);
    exp_err = 1'b1;
    clr_inputs();
    step("t5_sticky", IDLE);
    step("t5_sticky2", IDLE);

    // asynchronous reset in the middle of a memory wait
    ex_mem_en = 1;
    step("rs_issue", WAITV);
    step("rs_wait", WAITV);
    clr_inputs();
    do_reset();
    step("rs_run", IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
